// File: rtl/regarb_pkg.sv
// ----------------------------------------------------------------------------
// regarb_pkg
//   Shared definitions for the register-bank write arbiter:
//     - half-word mask encodings understood by the register cells
//     - arbiter state encoding
//     - mask legality check (combinations that would produce no write)
// ----------------------------------------------------------------------------
package regarb_pkg;

    localparam logic [1:0] MASK_ZERO = 2'b00;
    localparam logic [1:0] MASK_LO   = 2'b01;
    localparam logic [1:0] MASK_HI   = 2'b10;
    localparam logic [1:0] MASK_FULL = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // A cleared destination mask writes nothing unless the source is the
    // full word; every other combination reaches the register cells.
    function automatic logic mask_legal(input logic [1:0] in_mask,
                                        input logic [1:0] out_mask);
        return !((out_mask == MASK_ZERO) && (in_mask != MASK_FULL));
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_picker.sv
// ----------------------------------------------------------------------------
// rr_picker
//   Combinational round-robin selector. Searches the request vector starting
//   at index ptr, wrapping around, and returns the first request found.
//   Ports:
//     req       [NREQ-1:0]  request vector
//     ptr       [PW-1:0]    index where the search starts (< NREQ)
//     grant     [NREQ-1:0]  one-hot winner (all zero when nothing requests)
//     grant_idx [PW-1:0]    binary index of the winner
//     valid                 at least one request present
// ----------------------------------------------------------------------------
module rr_picker #(
    parameter int NREQ = 2,
    parameter int PW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [PW-1:0]   grant_idx,
    output logic            valid
);

    // Two passes: first the indices at or above the pointer, then the ones
    // below it. This gives the wrapped search order without modulo indexing.
    always_comb begin
        // NOTE: every output gets a default before any conditional assignment,
        // so no path leaves a value unassigned and no latch is inferred.
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i] && (i >= int'(ptr))) begin
                valid     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = PW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!valid && req[i] && (i < int'(ptr))) begin
                valid     = 1'b1;
                grant[i]  = 1'b1;
                grant_idx = PW'(i);
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// ----------------------------------------------------------------------------
// reg_write_arbiter
//   Shares the single write port of the general register bank between NREQ
//   requesters. One write is granted per cycle, round-robin; a requester may
//   hold ownership across several writes with its lock input. All outputs are
//   registered: arbitration in cycle t, bus and ack/err in cycle t+1.
//
//   Optional build macro: REGARB_CONFLICT_CNT_EN adds conflict_cnt, a
//   saturating count of cycles in which some request had to wait.
//
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     req      [NREQ-1:0]         write request, held until ack or err
//     lock     [NREQ-1:0]         keep ownership after this write
//     addr     [NREQ*AW-1:0]      target register per requester
//     data     [NREQ*N-1:0]       write data per requester
//     in_mask  [NREQ*2-1:0]       source-half select per requester
//     out_mask [NREQ*2-1:0]       destination-half select per requester
//     ack      [NREQ-1:0]         pulse: write issued this cycle
//     err      [NREQ-1:0]         pulse: request rejected, no write
//     reg_en   [NREG-1:0]         one-hot register write enable
//     reg_in   [N-1:0]            shared write data bus
//     reg_in_mask, reg_out_mask   shared mask buses
//     busy                        a lock is held
//     conflict_cnt [15:0]         (REGARB_CONFLICT_CNT_EN only)
// ----------------------------------------------------------------------------
module reg_write_arbiter
    import regarb_pkg::*;
#(
    parameter int N    = 16,
    parameter int NREG = 8,
    parameter int NREQ = 2,
    parameter int AW   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      lock,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*N-1:0]    data,
    input  logic [NREQ*2-1:0]    in_mask,
    input  logic [NREQ*2-1:0]    out_mask,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      err,
    output logic [NREG-1:0]      reg_en,
    output logic [N-1:0]         reg_in,
    output logic [1:0]           reg_in_mask,
    output logic [1:0]           reg_out_mask,
    output logic                 busy
`ifdef REGARB_CONFLICT_CNT_EN
    ,
    output logic [15:0]          conflict_cnt
`endif
);

    localparam int PW = $clog2(NREQ);

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [PW-1:0]   owner, owner_nxt;
    logic [NREQ-1:0] owner_bit;
    logic [NREQ-1:0] eligible;

    logic [NREQ-1:0] grant;
    logic [PW-1:0]   grant_idx;
    logic            pick_valid;

    logic [AW-1:0]   sel_addr;
    logic [N-1:0]    sel_data;
    logic [1:0]      sel_in;
    logic [1:0]      sel_out;
    logic            sel_lock;
    logic            sel_legal;

    logic [NREQ-1:0] ack_nxt, err_nxt;
    logic [NREG-1:0] reg_en_nxt;
    logic [N-1:0]    reg_in_nxt;
    logic [1:0]      in_m_nxt, out_m_nxt;
    logic            busy_nxt;

    assign owner_bit = NREQ'(1) << owner;

    // While locked only the owner competes, and its own ack does not hold it
    // off. Otherwise a requester answered this cycle sits out one round so a
    // held req is not granted twice for the same transaction.
    assign eligible = (state == ST_LOCKED) ? (req & owner_bit)
                                           : (req & ~(ack | err));

    rr_picker #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_picker (
        .req       (eligible),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .valid     (pick_valid)
    );

    // One-hot mux of the winning requester's fields.
    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_in   = '0;
        sel_out  = '0;
        sel_lock = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_addr = addr[i*AW +: AW];
                sel_data = data[i*N +: N];
                sel_in   = in_mask[i*2 +: 2];
                sel_out  = out_mask[i*2 +: 2];
                sel_lock = lock[i];
            end
        end
    end

    // Out-of-range addresses are rejected like illegal masks; the extra bit
    // keeps the compare meaningful when NREG is exactly 2**AW.
    assign sel_legal = mask_legal(sel_in, sel_out) &&
                       ({1'b0, sel_addr} < (AW+1)'(NREG));

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        owner_nxt  = owner;
        ack_nxt    = '0;
        err_nxt    = '0;
        reg_en_nxt = '0;
        reg_in_nxt = reg_in;
        in_m_nxt   = reg_in_mask;
        out_m_nxt  = reg_out_mask;

        if (pick_valid) begin
            ptr_nxt = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
            if (sel_legal) begin
                ack_nxt    = grant;
                reg_en_nxt = NREG'(1) << sel_addr;
                reg_in_nxt = sel_data;
                in_m_nxt   = sel_in;
                out_m_nxt  = sel_out;
            end else begin
                err_nxt = grant;
            end
        end

        unique case (state)
            ST_IDLE: begin
                if (pick_valid && sel_legal && sel_lock) begin
                    state_nxt = ST_LOCKED;
                    owner_nxt = grant_idx;
                end
            end
            ST_LOCKED: begin
                // Dropping lock releases ownership whether or not the owner
                // is writing this cycle; a concurrent write still issues.
                if (!(|(lock & owner_bit))) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt == ST_LOCKED);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the whole output stage, not just the FSM, is reset so that a
        // write in flight at reset assertion is dropped immediately.
        if (!rst_n) begin
            state        <= ST_IDLE;
            ptr          <= '0;
            owner        <= '0;
            ack          <= '0;
            err          <= '0;
            reg_en       <= '0;
            reg_in       <= '0;
            reg_in_mask  <= '0;
            reg_out_mask <= '0;
            busy         <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments for all state, so every flop
            // samples the pre-edge values regardless of statement order.
            state        <= state_nxt;
            ptr          <= ptr_nxt;
            owner        <= owner_nxt;
            ack          <= ack_nxt;
            err          <= err_nxt;
            reg_en       <= reg_en_nxt;
            reg_in       <= reg_in_nxt;
            reg_in_mask  <= in_m_nxt;
            reg_out_mask <= out_m_nxt;
            busy         <= busy_nxt;
        end
    end

`ifdef REGARB_CONFLICT_CNT_EN
    // A cycle counts as a conflict when arbitration actually had to choose,
    // or when a non-owner is being held off by a lock.
    logic conflict;

    assign conflict = (state == ST_LOCKED) ? (|(req & ~owner_bit))
                                           : ($countones(eligible) >= 2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (conflict && (conflict_cnt != 16'hFFFF)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_reg_write_arbiter
//   Directed scenarios followed by randomized traffic. Every driven cycle the
//   reference model predicts the registered outputs for the next cycle and
//   queues them; an independent monitor compares on each falling edge.
//   A small register-cell model consumes the DUT's write bus so register
//   contents can be checked two cycles after a request.
// ----------------------------------------------------------------------------
module tb_reg_write_arbiter;

    localparam int N    = 16;
    localparam int NREG = 8;
    localparam int NREQ = 2;
    localparam int AW   = 3;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req = '0;
    logic [NREQ-1:0]      lock = '0;
    logic [NREQ*AW-1:0]   addr = '0;
    logic [NREQ*N-1:0]    data = '0;
    logic [NREQ*2-1:0]    in_mask = '0;
    logic [NREQ*2-1:0]    out_mask = '0;
    logic [NREQ-1:0]      ack;
    logic [NREQ-1:0]      err;
    logic [NREG-1:0]      reg_en;
    logic [N-1:0]         reg_in;
    logic [1:0]           reg_in_mask;
    logic [1:0]           reg_out_mask;
    logic                 busy;
`ifdef REGARB_CONFLICT_CNT_EN
    logic [15:0]          conflict_cnt;
`endif

    reg_write_arbiter #(.N(N), .NREG(NREG), .NREQ(NREQ), .AW(AW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .lock         (lock),
        .addr         (addr),
        .data         (data),
        .in_mask      (in_mask),
        .out_mask     (out_mask),
        .ack          (ack),
        .err          (err),
        .reg_en       (reg_en),
        .reg_in       (reg_in),
        .reg_in_mask  (reg_in_mask),
        .reg_out_mask (reg_out_mask),
        .busy         (busy)
`ifdef REGARB_CONFLICT_CNT_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- register cells fed by the DUT write bus ----------------
    logic [N-1:0] bank [NREG] = '{default: '0};

    function automatic logic [N-1:0] cell_write(input logic [N-1:0] cur,
        input logic [N-1:0] d, input logic [1:0] im, input logic [1:0] om);
        logic [7:0]   src;
        logic [N-1:0] r;
        r = cur;
        case (im)
            2'b01:   src = d[7:0];
            2'b10:   src = d[15:8];
            default: src = 8'h00;
        endcase
        case (om)
            2'b11: r = (im == 2'b11) ? d : {8'h00, src};
            2'b01: r[7:0]  = (im == 2'b11) ? d[7:0]  : src;
            2'b10: r[15:8] = (im == 2'b11) ? d[15:8] : src;
            default: r = cur;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        for (int r = 0; r < NREG; r++)
            if (reg_en[r]) bank[r] <= cell_write(bank[r], reg_in, reg_in_mask, reg_out_mask);
    end

    // ---------------- reference model and scoreboard ----------------
    typedef struct {
        int              cyc;
        logic [NREQ-1:0] ack;
        logic [NREQ-1:0] err;
        logic [NREG-1:0] reg_en;
        logic [N-1:0]    d;
        logic [1:0]      im;
        logic [1:0]      om;
        bit              busy;
        bit              known;
        int              cnt;
    } exp_t;

    exp_t q[$];

    int              m_ptr;
    bit              m_locked;
    int              m_owner;
    logic [NREQ-1:0] m_pulse;
    logic [N-1:0]    m_d;
    logic [1:0]      m_im, m_om;
    bit              m_known;
    int              m_cnt;

    task automatic model_reset();
        m_ptr    = 0;
        m_locked = 0;
        m_owner  = 0;
        m_pulse  = '0;
        m_d      = '0;
        m_im     = '0;
        m_om     = '0;
        m_known  = 1;
        m_cnt    = 0;
        q.delete();
    endtask

    // Predict the outputs that follow the inputs currently applied.
    task automatic model_step();
        logic [NREQ-1:0] elig;
        int    w, n, a;
        bit    legal, waiting;
        logic [1:0] im, om;
        exp_t  e;
        elig    = '0;
        n       = 0;
        waiting = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (m_locked) begin
                elig[i] = req[i] && (i == m_owner);
                if (req[i] && i != m_owner) waiting = 1;
            end else begin
                elig[i] = req[i] && !m_pulse[i];
            end
            if (elig[i]) n++;
        end
        if (((!m_locked && n >= 2) || waiting) && m_cnt < 65535) m_cnt++;

        w = -1;
        for (int k = 0; k < NREQ; k++)
            if (w < 0 && elig[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;

        e.ack = '0; e.err = '0; e.reg_en = '0;
        if (w >= 0) begin
            a  = int'(addr[w*AW +: AW]);
            im = in_mask[w*2 +: 2];
            om = out_mask[w*2 +: 2];
            legal = !(om == 2'b00 && im != 2'b11) && (a < NREG);
            if (legal) begin
                e.ack[w]    = 1'b1;
                e.reg_en[a] = 1'b1;
                m_d = data[w*N +: N]; m_im = im; m_om = om; m_known = 1;
            end else begin
                e.err[w] = 1'b1;
                m_known  = 0;
            end
            m_ptr = (w + 1) % NREQ;
            if (m_locked) begin
                if (!lock[w]) m_locked = 0;
            end else if (legal && lock[w]) begin
                m_locked = 1;
                m_owner  = w;
            end
        end else if (m_locked && !lock[m_owner]) begin
            m_locked = 0;
        end
        m_pulse = e.ack | e.err;
        e.cyc   = cyc + 1;
        e.d     = m_d;
        e.im    = m_im;
        e.om    = m_om;
        e.busy  = m_locked;
        e.known = m_known;
        e.cnt   = m_cnt;
        q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                check("stale_expectation", 32'(e.cyc), 32'(cyc));
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                check("ack", 32'(ack), 32'(e.ack));
                check("err", 32'(err), 32'(e.err));
                check("reg_en", 32'(reg_en), 32'(e.reg_en));
                check("busy", 32'(busy), 32'(e.busy));
                if (e.known) begin
                    check("reg_in", 32'(reg_in), 32'(e.d));
                    check("reg_in_mask", 32'(reg_in_mask), 32'(e.im));
                    check("reg_out_mask", 32'(reg_out_mask), 32'(e.om));
                end
`ifdef REGARB_CONFLICT_CNT_EN
                check("conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
`endif
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic slot();
        @(posedge clk);
        #2;
    endtask

    task automatic set_req(input int i, input int a, input logic [N-1:0] d,
                           input logic [1:0] im, input logic [1:0] om, input bit lk);
        req[i]             = 1'b1;
        lock[i]            = lk;
        addr[i*AW +: AW]   = AW'(a);
        data[i*N +: N]     = d;
        in_mask[i*2 +: 2]  = im;
        out_mask[i*2 +: 2] = om;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            slot();
            req  = '0;
            lock = '0;
            model_step();
        end
    endtask

    bit pend [NREQ];

    initial begin : stimulus
        model_reset();
        #3;
        check("rst_ack", 32'(ack), 32'h0);
        check("rst_err", 32'(err), 32'h0);
        check("rst_reg_en", 32'(reg_en), 32'h0);
        check("rst_reg_in", 32'(reg_in), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        #9 rst_n = 1'b1;

        // Contention from pointer 0: grants alternate 0,1,0,1,0.
        slot();
        set_req(0, 1, 16'h1111, 2'b11, 2'b11, 1'b0);
        set_req(1, 2, 16'h2222, 2'b11, 2'b11, 1'b0);
        model_step();
        for (int k = 0; k < 4; k++) begin
            slot();
            model_step();
        end
        idle_cycles(2);

        // Single full write to register 3, visible two cycles later.
        slot();
        set_req(0, 3, 16'hABCD, 2'b11, 2'b11, 1'b0);
        model_step();
        idle_cycles(2);
        check("bank3", 32'(bank[3]), 32'h0000ABCD);

        // Illegal mask from requester 1.
        slot();
        set_req(1, 4, 16'h5555, 2'b01, 2'b00, 1'b0);
        model_step();
        idle_cycles(2);

        // Lock: requester 0 writes 1,2,3 back to back while requester 1 waits.
        slot();
        set_req(0, 1, 16'h0101, 2'b11, 2'b11, 1'b1);
        model_step();
        slot();
        set_req(0, 2, 16'h0202, 2'b11, 2'b11, 1'b1);
        set_req(1, 6, 16'h0606, 2'b11, 2'b11, 1'b0);
        model_step();
        slot();
        set_req(0, 3, 16'h0303, 2'b11, 2'b11, 1'b0);
        model_step();
        slot();
        req[0] = 1'b0;
        model_step();
        slot();
        model_step();
        idle_cycles(2);

        // Half write: high source half into the low half of register 5.
        slot();
        set_req(0, 5, 16'h1234, 2'b10, 2'b01, 1'b0);
        model_step();
        idle_cycles(2);
        check("bank5", 32'(bank[5]), 32'h00000012);

        // Reset while locked.
        slot();
        set_req(0, 1, 16'h7777, 2'b11, 2'b11, 1'b1);
        model_step();
        slot();
        set_req(0, 2, 16'h8888, 2'b11, 2'b11, 1'b1);
        model_step();
        #5;
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        #1;
        check("midrst_ack", 32'(ack), 32'h0);
        check("midrst_reg_en", 32'(reg_en), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
`ifdef REGARB_CONFLICT_CNT_EN
        check("midrst_cnt", 32'(conflict_cnt), 32'h0);
`endif
        model_reset();
        #5 rst_n = 1'b1;
        slot();
        set_req(1, 7, 16'h9999, 2'b11, 2'b11, 1'b0);
        model_step();
        idle_cycles(2);

        // Randomized traffic.
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        for (int c = 0; c < 3000; c++) begin
            slot();
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] || m_pulse[i]) begin
                    if ($urandom_range(0, 99) < 60) begin
                        pend[i] = 1;
                        set_req(i, int'($urandom_range(0, NREG - 1)), N'($urandom),
                                2'($urandom_range(0, 3)),
                                ($urandom_range(0, 9) == 0) ? 2'b00 : 2'($urandom_range(1, 3)),
                                $urandom_range(0, 99) < 20);
                    end else begin
                        pend[i] = 0;
                        req[i]  = 1'b0;
                        lock[i] = 1'($urandom_range(0, 1));
                    end
                end
            end
            model_step();
        end
        idle_cycles(3);

        for (int k = 0; k < 10 && q.size() > 0; k++) @(negedge clk);
        #1;
        check("drain", 32'(q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
